// File: rtl/ext_unit.sv
// ext_unit: immediate / load-lane operand extender feeding a 2-entry in-order
// result buffer with valid/ready handshakes on both sides.
`default_nettype none

module ext_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  localparam int OFF_W = $clog2(OUT_W/8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [2:0]       i_mode,
  input  logic [OUT_W-1:0] i_data,
  input  logic [OFF_W-1:0] i_off,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_misalign
);

  localparam int SH_W = OFF_W + 3;
  // Halfword lanes ignore offset bit 0, i.e. bit 3 of the bit-shift amount.
  localparam logic [SH_W-1:0] HALF_MASK = ~(SH_W'(8));

  localparam logic [2:0] MODE_SEXT   = 3'b000;
  localparam logic [2:0] MODE_ZEXT   = 3'b001;
  localparam logic [2:0] MODE_UPPER  = 3'b010;
  localparam logic [2:0] MODE_BRANCH = 3'b011;
  localparam logic [2:0] MODE_LB     = 3'b100;
  localparam logic [2:0] MODE_LBU    = 3'b101;
  localparam logic [2:0] MODE_LH     = 3'b110;
  localparam logic [2:0] MODE_LHU    = 3'b111;

  logic [IN_W-1:0]  imm;
  logic [OUT_W-1:0] imm_sext;
  logic [SH_W-1:0]  byte_sh;
  logic [SH_W-1:0]  half_sh;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [OUT_W-1:0] ext;
  logic             ext_mis;

  always_comb begin
    imm       = i_data[IN_W-1:0];
    imm_sext  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    byte_sh   = {i_off, 3'b000};
    half_sh   = byte_sh & HALF_MASK;
    byte_lane = 8'(i_data >> byte_sh);
    half_lane = 16'(i_data >> half_sh);
    ext_mis   = i_mode[2] & i_mode[1] & i_off[0];
    ext       = imm_sext;
    case (i_mode)
      MODE_SEXT:   ext = imm_sext;
      MODE_ZEXT:   ext = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_UPPER:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: ext = imm_sext << 2;
      MODE_LB:     ext = {{(OUT_W-8){byte_lane[7]}}, byte_lane};
      MODE_LBU:    ext = {{(OUT_W-8){1'b0}}, byte_lane};
      MODE_LH:     ext = {{(OUT_W-16){half_lane[15]}}, half_lane};
      MODE_LHU:    ext = {{(OUT_W-16){1'b0}}, half_lane};
      default:     ext = imm_sext;
    endcase
  end

  logic [OUT_W-1:0] mem_data [2];
  logic             mem_mis  [2];
  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             rd_nxt;
  logic             push;
  logic             pop;
  logic             head_from_in;
  logic [OUT_W-1:0] head_data_nxt;
  logic             head_mis_nxt;

  assign i_ready = (count != 2'd2);
  assign o_valid = (count != 2'd0);
  assign push    = i_valid & i_ready;
  assign pop     = o_valid & o_ready;

  // The output register tracks the head for the coming cycle; if that slot is
  // being written this edge, the head must come straight from the extender.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
    rd_nxt        = pop ? ~rd_ptr : rd_ptr;
    head_from_in  = push && (wr_ptr == rd_nxt);
    head_data_nxt = head_from_in ? ext     : mem_data[rd_nxt];
    head_mis_nxt  = head_from_in ? ext_mis : mem_mis[rd_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      o_data     <= '0;
      o_misalign <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        mem_data[k] <= '0;
        mem_mis[k]  <= 1'b0;
      end
    end else if (i_flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= ext;
        mem_mis[wr_ptr]  <= ext_mis;
        wr_ptr           <= ~wr_ptr;
      end
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      if (count_nxt != 2'd0) begin
        o_data     <= head_data_nxt;
        o_misalign <= head_mis_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ext_unit.sv
// Directed self-checking bench for ext_unit with hand-computed expectations.
`default_nettype none

module tb_ext_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [2:0]  i_mode = 3'b000;
  logic [31:0] i_data = 32'h0;
  logic [1:0]  i_off = 2'd0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [31:0] o_data;
  logic        o_misalign;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ext_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_mode     (i_mode),
    .i_data     (i_data),
    .i_off      (i_off),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_misalign (o_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one transaction with o_ready high, then check the result one cycle later.
  task automatic xfer(input string tag, input logic [2:0] mode, input logic [31:0] data,
                      input logic [1:0] off, input logic [31:0] exp, input logic mis);
    i_valid = 1'b1;
    i_mode  = mode;
    i_data  = data;
    i_off   = off;
    step();
    chk({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
    chk({tag, "_data"}, o_data, exp);
    chk({tag, "_mis"}, {31'b0, o_misalign}, {31'b0, mis});
  endtask

  initial begin
    #2;
    chk("rst_o_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_o_data", o_data, 32'h0);
    chk("rst_o_mis", {31'b0, o_misalign}, 32'd0);
    chk("rst_i_ready", {31'b0, i_ready}, 32'd1);
    #10 rst_n = 1'b1;
    step();

    // Immediate modes
    o_ready = 1'b1;
    xfer("sext",   3'b000, 32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0);
    xfer("zext",   3'b001, 32'h0000_8001, 2'd0, 32'h0000_8001, 1'b0);
    xfer("upper",  3'b010, 32'h0000_8001, 2'd0, 32'h8001_0000, 1'b0);
    xfer("branch", 3'b011, 32'h0000_8001, 2'd0, 32'hFFFE_0004, 1'b0);
    xfer("sext_hi_ignored", 3'b000, 32'h1234_0005, 2'd0, 32'h0000_0005, 1'b0);

    // Load modes
    xfer("lb_off0",  3'b100, 32'h80F1_7F82, 2'd0, 32'hFFFF_FF82, 1'b0);
    xfer("lbu_off2", 3'b101, 32'h80F1_7F82, 2'd2, 32'h0000_00F1, 1'b0);
    xfer("lh_off2",  3'b110, 32'h80F1_7F82, 2'd2, 32'hFFFF_80F1, 1'b0);
    xfer("lhu_off0", 3'b111, 32'h80F1_7F82, 2'd0, 32'h0000_7F82, 1'b0);
    xfer("lh_off3",  3'b110, 32'h80F1_7F82, 2'd3, 32'hFFFF_80F1, 1'b1);
    xfer("lb_off1",  3'b100, 32'h80F1_7F82, 2'd1, 32'h0000_007F, 1'b0);
    xfer("lhu_off1", 3'b111, 32'h80F1_7F82, 2'd1, 32'h0000_7F82, 1'b1);
    xfer("lbu_off3", 3'b101, 32'h80F1_7F82, 2'd3, 32'h0000_0080, 1'b0);
    i_valid = 1'b0;
    step();
    chk("drain_valid", {31'b0, o_valid}, 32'd0);
    chk("drain_hold_data", o_data, 32'h0000_0080);

    // Backpressure
    o_ready = 1'b0;
    i_mode  = 3'b001;
    i_off   = 2'd0;
    i_valid = 1'b1;
    i_data  = 32'h11;
    step();
    chk("bp_a_ready", {31'b0, i_ready}, 32'd1);
    chk("bp_a_data", o_data, 32'h11);
    i_data = 32'h22;
    step();
    chk("bp_full_ready", {31'b0, i_ready}, 32'd0);
    chk("bp_full_valid", {31'b0, o_valid}, 32'd1);
    i_data = 32'h33;
    step();
    chk("bp_third_blocked", {31'b0, i_ready}, 32'd0);
    chk("bp_head_stable", o_data, 32'h11);
    o_ready = 1'b1;
    #1;
    chk("bp_out0", o_data, 32'h11);
    step();
    chk("bp_out1", o_data, 32'h22);
    chk("bp_out1_valid", {31'b0, o_valid}, 32'd1);
    chk("bp_ready_again", {31'b0, i_ready}, 32'd1);
    step();
    chk("bp_out2", o_data, 32'h33);
    i_valid = 1'b0;
    step();
    chk("bp_empty", {31'b0, o_valid}, 32'd0);

    // Streaming
    i_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      i_data = 32'h100 + 32'(i);
      step();
      chk("stream_valid", {31'b0, o_valid}, 32'd1);
      chk("stream_data", o_data, 32'h100 + 32'(i));
      chk("stream_count_le1", {31'b0, i_ready}, 32'd1);
    end
    i_valid = 1'b0;
    step();
    chk("stream_done", {31'b0, o_valid}, 32'd0);

    // Flush with count 2
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hAA;
    step();
    i_data = 32'hBB;
    step();
    chk("fl_full", {31'b0, i_ready}, 32'd0);
    i_data  = 32'hCC;
    o_ready = 1'b1;
    i_flush = 1'b1;
    step();
    chk("fl_valid", {31'b0, o_valid}, 32'd0);
    chk("fl_ready", {31'b0, i_ready}, 32'd1);
    chk("fl_data_held", o_data, 32'hAA);
    i_flush = 1'b0;
    i_valid = 1'b0;
    step();
    chk("fl_stays_empty", {31'b0, o_valid}, 32'd0);
    xfer("fl_next", 3'b001, 32'hDD, 2'd0, 32'hDD, 1'b0);

    // Flush with count 1 plus simultaneous push and pop
    i_data  = 32'hEE;
    i_flush = 1'b1;
    step();
    chk("fl1_valid", {31'b0, o_valid}, 32'd0);
    chk("fl1_data_held", o_data, 32'hDD);
    i_flush = 1'b0;
    i_valid = 1'b0;
    step();
    chk("fl1_no_emit", {31'b0, o_valid}, 32'd0);
    xfer("fl1_next", 3'b001, 32'h77, 2'd0, 32'h77, 1'b0);
    i_valid = 1'b0;
    step();
    chk("fl1_drain", {31'b0, o_valid}, 32'd0);

    // Asynchronous reset with count 2
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h55;
    step();
    i_data = 32'h66;
    step();
    chk("rr_full", {31'b0, i_ready}, 32'd0);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rr_valid", {31'b0, o_valid}, 32'd0);
    chk("rr_data", o_data, 32'h0);
    chk("rr_ready", {31'b0, i_ready}, 32'd1);
    #8 rst_n = 1'b1;
    step();
    chk("rr_post_valid", {31'b0, o_valid}, 32'd0);
    o_ready = 1'b1;
    xfer("rr_first", 3'b001, 32'h99, 2'd0, 32'h99, 1'b0);
    i_valid = 1'b0;
    step();
    chk("rr_no_old", {31'b0, o_valid}, 32'd0);
    chk("rr_hold", o_data, 32'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
